// File: rtl/time_param_timer.sv
`default_nettype none
// time_param_timer: programmable delay bank with registered readback and an
// integrated countdown timer driven by a 1 Hz tick enable.
module time_param_timer #(
  parameter int                            NUM_PARAMS = 4,
  parameter int                            VALUE_W    = 4,
  parameter int                            SEL_W      = 2,
  parameter logic [NUM_PARAMS*VALUE_W-1:0] DEFAULTS   = {4'hA, 4'hF, 4'h8, 4'h6},
  parameter int                            MIN_VALUE  = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SEL_W-1:0]   interval,
  input  logic [SEL_W-1:0]   time_param_sel,
  input  logic               reprogram,
  input  logic [VALUE_W-1:0] time_value,
  input  logic               start_timer,
  input  logic               tick,
  input  logic               abort,
  output logic [VALUE_W-1:0] value,
  output logic [VALUE_W-1:0] count,
  output logic               busy,
  output logic               expired,
  output logic               prog_error
);

  localparam logic [SEL_W:0]     c_NUM = NUM_PARAMS[SEL_W:0];
  localparam logic [VALUE_W-1:0] c_MIN = MIN_VALUE[VALUE_W-1:0];
  localparam logic [VALUE_W-1:0] c_ONE = {{(VALUE_W-1){1'b0}}, 1'b1};

  // One-hot so busy/expired are taken straight from flop outputs.
  localparam logic [2:0] c_IDLE   = 3'b001;
  localparam logic [2:0] c_COUNT  = 3'b010;
  localparam logic [2:0] c_EXPIRE = 3'b100;

  logic [VALUE_W-1:0] r_bank [NUM_PARAMS];
  logic [VALUE_W-1:0] r_value;
  logic [VALUE_W-1:0] r_count;
  logic [2:0]         r_state;
  logic               r_prog_error;

  logic               w_sel_ok;
  logic               w_int_ok;
  logic               w_wr_ok;
  logic [VALUE_W-1:0] w_bank_sel;
  logic [2:0]         w_state_nxt;
  logic [VALUE_W-1:0] w_count_nxt;

  assign w_sel_ok = ({1'b0, time_param_sel} < c_NUM);
  assign w_int_ok = ({1'b0, interval} < c_NUM);
  assign w_wr_ok  = reprogram && w_sel_ok && (time_value >= c_MIN);

  always_comb begin
    w_bank_sel = '0;
    if (w_int_ok) w_bank_sel = r_bank[interval];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        r_bank[i] <= DEFAULTS[i*VALUE_W +: VALUE_W];
      end
      r_value      <= DEFAULTS[VALUE_W-1:0];
      r_prog_error <= 1'b0;
    end else begin
      if (w_wr_ok) r_bank[time_param_sel] <= time_value;
      r_value      <= w_bank_sel;
      r_prog_error <= reprogram && !w_wr_ok;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Loads read the bank before any same-cycle write lands.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      c_IDLE: begin
        if (start_timer && w_int_ok) begin
          w_count_nxt = w_bank_sel;
          w_state_nxt = c_COUNT;
        end
      end
      c_COUNT: begin
        if (abort) begin
          w_count_nxt = '0;
          w_state_nxt = c_IDLE;
        end else if (start_timer && w_int_ok) begin
          w_count_nxt = w_bank_sel;
        end else if (tick) begin
          if (r_count > c_ONE) begin
            w_count_nxt = r_count - c_ONE;
          end else begin
            w_count_nxt = '0;
            w_state_nxt = c_EXPIRE;
          end
        end else if (r_count == '0) begin
          w_state_nxt = c_EXPIRE;
        end
      end
      c_EXPIRE: begin
        w_state_nxt = c_IDLE;
      end
      default: begin
        w_count_nxt = '0;
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  always_comb begin
    busy    = r_state[1];
    expired = r_state[2];
  end

  assign value      = r_value;
  assign count      = r_count;
  assign prog_error = r_prog_error;

endmodule
`default_nettype wire

// File: tb/tb_time_param_timer.sv
`default_nettype none
// Self-checking bench for time_param_timer: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_time_param_timer;

  localparam int S_IDLE = 0, S_COUNT = 1, S_EXPIRE = 2;
  localparam int DEF [4] = '{6, 8, 15, 10};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] interval = '0, time_param_sel = '0;
  logic       reprogram = 1'b0, start_timer = 1'b0, tick = 1'b0, abort = 1'b0;
  logic [3:0] time_value = '0;
  logic [3:0] value, count;
  logic       busy, expired, prog_error;

  int checks = 0;
  int failures = 0;

  int m_bank [4];
  int m_value, m_count, m_state, m_perr;
  int n_bank [4];
  int n_value, n_count, n_state, n_perr;

  time_param_timer dut (
    .clock(clock), .reset(reset), .interval(interval),
    .time_param_sel(time_param_sel), .reprogram(reprogram),
    .time_value(time_value), .start_timer(start_timer), .tick(tick),
    .abort(abort), .value(value), .count(count), .busy(busy),
    .expired(expired), .prog_error(prog_error)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_bank = DEF;
    m_value = DEF[0]; m_count = 0; m_state = S_IDLE; m_perr = 0;
  endtask

  task automatic model_eval();
    n_bank = m_bank;
    n_perr = 0;
    if (reprogram) begin
      if (int'(time_param_sel) < 4 && int'(time_value) >= 1) n_bank[time_param_sel] = int'(time_value);
      else n_perr = 1;
    end
    n_value = m_bank[interval];
    n_state = m_state;
    n_count = m_count;
    case (m_state)
      S_IDLE: if (start_timer) begin n_count = m_bank[interval]; n_state = S_COUNT; end
      S_COUNT: begin
        if (abort) begin n_count = 0; n_state = S_IDLE; end
        else if (start_timer) n_count = m_bank[interval];
        else if (tick) begin
          if (m_count > 1) n_count = m_count - 1;
          else begin n_count = 0; n_state = S_EXPIRE; end
        end else if (m_count == 0) n_state = S_EXPIRE;
      end
      default: n_state = S_IDLE;
    endcase
  endtask

  // One clock: model sees the same pre-edge inputs; compare #1 after the edge.
  task automatic step();
    model_eval();
    @(posedge clock);
    #1;
    if (!reset) model_reset();
    else begin
      m_bank = n_bank; m_value = n_value; m_count = n_count;
      m_state = n_state; m_perr = n_perr;
    end
  endtask

  task automatic idle_inputs();
    reprogram = 1'b0; start_timer = 1'b0; tick = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (value !== 4'd6) begin failures++; $display("FAIL reset_value got=%0d exp=6", value); end
    checks++; if (count !== 4'd0 || busy !== 1'b0 || expired !== 1'b0 || prog_error !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got count=%0d busy=%b exp=%b perr=%b exp 0/0/0/0", count, busy, expired, prog_error);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_readback(input string tag);
    for (int i = 0; i < 4; i++) begin
      interval = 2'(i);
      step();
      checks++; if (value !== 4'(DEF[i])) begin failures++; $display("FAIL %s_value[%0d] got=%0d exp=%0d", tag, i, value, DEF[i]); end
      checks++; if (busy !== 1'b0 || expired !== 1'b0) begin failures++; $display("FAIL %s_idle[%0d] got busy=%b expired=%b exp 0/0", tag, i, busy, expired); end
    end
  endtask

  task automatic test_reprogram();
    interval = 2'd1; time_param_sel = 2'd1; time_value = 4'd3; reprogram = 1'b1;
    step();
    reprogram = 1'b0;
    checks++; if (value !== 4'd8) begin failures++; $display("FAIL wr_latency_early got=%0d exp=8", value); end
    step();
    checks++; if (value !== 4'd3) begin failures++; $display("FAIL wr_value got=%0d exp=3", value); end
    interval = 2'd2; time_param_sel = 2'd2; time_value = 4'd0; reprogram = 1'b1;
    step();
    reprogram = 1'b0;
    checks++; if (prog_error !== 1'b1) begin failures++; $display("FAIL prog_error_pulse got=%b exp=1", prog_error); end
    step();
    checks++; if (prog_error !== 1'b0) begin failures++; $display("FAIL prog_error_clear got=%b exp=0", prog_error); end
    checks++; if (value !== 4'd15) begin failures++; $display("FAIL rejected_write got=%0d exp=15", value); end
    time_param_sel = 2'd1; time_value = 4'd8; reprogram = 1'b1;
    step();
    reprogram = 1'b0;
  endtask

  task automatic test_countdown();
    int exp_cnt;
    interval = 2'd0; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    checks++; if (busy !== 1'b1 || count !== 4'd6) begin failures++; $display("FAIL cd_start got busy=%b count=%0d exp 1/6", busy, count); end
    for (int t = 1; t <= 6; t++) begin
      repeat (4) begin
        step();
        checks++; if (expired !== 1'b0) begin failures++; $display("FAIL cd_early_expire tick=%0d got=%b exp=0", t, expired); end
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
      exp_cnt = 6 - t;
      checks++; if (count !== 4'(exp_cnt)) begin failures++; $display("FAIL cd_count tick=%0d got=%0d exp=%0d", t, count, exp_cnt); end
    end
    checks++; if (expired !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL cd_expire got expired=%b busy=%b exp 1/0", expired, busy); end
    step();
    checks++; if (expired !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL cd_after got expired=%b busy=%b exp 0/0", expired, busy); end
  endtask

  task automatic test_restart_abort();
    interval = 2'd3; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    repeat (4) begin tick = 1'b1; step(); tick = 1'b0; step(); end
    checks++; if (count !== 4'd6) begin failures++; $display("FAIL ra_after4 got=%0d exp=6", count); end
    start_timer = 1'b1; tick = 1'b1;
    step();
    idle_inputs();
    checks++; if (count !== 4'd10 || busy !== 1'b1) begin failures++; $display("FAIL ra_reload got count=%0d busy=%b exp 10/1", count, busy); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (count !== 4'd0 || busy !== 1'b0 || expired !== 1'b0) begin
      failures++; $display("FAIL ra_abort got count=%0d busy=%b expired=%b exp 0/0/0", count, busy, expired);
    end
    repeat (3) begin
      step();
      checks++; if (expired !== 1'b0) begin failures++; $display("FAIL ra_no_expire got=%b exp=0", expired); end
    end
  endtask

  task automatic test_reprogram_during_count();
    int ticks = 0;
    interval = 2'd1; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL rdc_load got=%0d exp=8", count); end
    while (expired !== 1'b1 && ticks < 20) begin
      tick = 1'b1;
      if (ticks == 2) begin reprogram = 1'b1; time_param_sel = 2'd1; time_value = 4'd2; end
      step();
      idle_inputs();
      ticks++;
    end
    checks++; if (ticks !== 8) begin failures++; $display("FAIL rdc_ticks got=%0d exp=8", ticks); end
    step();
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL rdc_new_load got=%0d exp=2", count); end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_async_reset();
    interval = 2'd0; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    repeat (2) begin tick = 1'b1; step(); tick = 1'b0; end
    checks++; if (count !== 4'd4) begin failures++; $display("FAIL ar_pre got=%0d exp=4", count); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++; if (count !== 4'd0 || busy !== 1'b0 || expired !== 1'b0) begin
      failures++; $display("FAIL ar_immediate got count=%0d busy=%b expired=%b exp 0/0/0", count, busy, expired);
    end
    repeat (3) begin
      tick = 1'b1;
      step();
      checks++; if (expired !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ar_hold got expired=%b busy=%b exp 0/0", expired, busy); end
    end
    tick = 1'b0;
    reset = 1'b1;
    step();
    test_readback("ar");
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      interval       = 2'($urandom_range(0, 3));
      time_param_sel = 2'($urandom_range(0, 3));
      time_value     = 4'($urandom_range(0, 15));
      reprogram      = ($urandom_range(0, 7) == 0);
      start_timer    = ($urandom_range(0, 11) == 0);
      tick           = ($urandom_range(0, 2) == 0);
      abort          = ($urandom_range(0, 39) == 0);
      step();
      checks++;
      if (value !== 4'(m_value) || count !== 4'(m_count) || busy !== (m_state == S_COUNT) ||
          expired !== (m_state == S_EXPIRE) || prog_error !== 1'(m_perr)) begin
        failures++;
        $display("FAIL rand cyc=%0d got v=%0d c=%0d b=%b e=%b p=%b exp v=%0d c=%0d b=%b e=%b p=%0d",
                 c, value, count, busy, expired, prog_error, m_value, m_count,
                 m_state == S_COUNT, m_state == S_EXPIRE, m_perr);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_readback("rb");
    test_reprogram();
    test_countdown();
    test_restart_abort();
    test_reprogram_during_count();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
